// File: rtl/uart_tx_fifo.sv
// UART transmitter with internal baud divider, transmit FIFO and valid/ready input.
// Frames: start bit, DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,   // 0 none, 1 odd, 2 even
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_BITS-1:0]                 tx_data,
    input  logic                                 tx_valid,
    output logic                                 tx_ready,
    output logic                                 rs232_tx,
    output logic                                 tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

    localparam int unsigned DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned NW  = 4;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // FIFO storage; pointers carry an extra wrap bit so full and empty differ
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 full, empty, push, pop;
    logic [DATA_BITS-1:0] head;

    assign count      = wr_ptr - rd_ptr;
    assign full       = (count == CW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign push       = tx_valid && !full;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign tx_ready   = !full;
    assign fifo_count = count;

    // FIFO write port; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
    end

    // FIFO pointer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Transmit state
    state_e               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [NW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 head_par;

    assign head_par = (PARITY == 1) ? ~^head : ^head;
    assign tx_busy  = (state_q != StIdle);
    assign rs232_tx = tx_q;

    // Transmit state registers; line idles high and reset abandons any frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic: every non-idle bit lasts DIV cycles, counted down to zero
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (state_q == StIdle) begin
            if (!empty) begin
                pop     = 1'b1;
                shift_d = head;
                par_d   = head_par;
                tx_d    = 1'b0;
                baud_d  = BW'(DIV - 1);
                state_d = StStart;
            end
        end else if (baud_q != '0) begin
            baud_d = baud_q - 1'b1;
        end else begin
            baud_d = BW'(DIV - 1);
            unique case (state_q)
                StStart: begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                    state_d = StData;
                end
                StData: begin
                    if (bit_q == NW'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            tx_d    = par_q;
                            state_d = StParity;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = StStop;
                        end
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                    end
                end
                StParity: begin
                    tx_d    = 1'b1;
                    bit_d   = '0;
                    state_d = StStop;
                end
                StStop: begin
                    if (bit_q == NW'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        // Chain straight into the next start bit when more data waits
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = head_par;
                            tx_d    = 1'b0;
                            state_d = StStart;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = StIdle;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: four instances (8N1, 8E1, 8O1, 7N2), DIV=16, depth 4.
module tb_uart_tx_fifo;

    localparam int DIV = 16;

    logic       clk;
    logic       rst;
    logic [8:0] data  [4];
    logic       valid [4];
    logic       rdy   [4];
    logic       line  [4];
    logic       busy  [4];
    logic [2:0] cnt   [4];

    int         errors;
    int         checks;
    logic [8:0] sb_q [$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_n1 (
        .clk(clk), .rst(rst), .tx_data(data[0][7:0]), .tx_valid(valid[0]), .tx_ready(rdy[0]),
        .rs232_tx(line[0]), .tx_busy(busy[0]), .fifo_count(cnt[0]));
    uart_tx_fifo #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_e1 (
        .clk(clk), .rst(rst), .tx_data(data[1][7:0]), .tx_valid(valid[1]), .tx_ready(rdy[1]),
        .rs232_tx(line[1]), .tx_busy(busy[1]), .fifo_count(cnt[1]));
    uart_tx_fifo #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_o1 (
        .clk(clk), .rst(rst), .tx_data(data[2][7:0]), .tx_valid(valid[2]), .tx_ready(rdy[2]),
        .rs232_tx(line[2]), .tx_busy(busy[2]), .fifo_count(cnt[2]));
    uart_tx_fifo #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_n2 (
        .clk(clk), .rst(rst), .tx_data(data[3][6:0]), .tx_valid(valid[3]), .tx_ready(rdy[3]),
        .rs232_tx(line[3]), .tx_busy(busy[3]), .fifo_count(cnt[3]));

    // Pops expected words and checks every cycle of each frame against the bit model.
    // Frames must follow each other with no gap; line must be idle afterwards.
    task automatic expect_frames(input int d, input int n, input int nbits, input int par,
                                 input int stops);
        int         t;
        logic [8:0] w;
        logic       b [16];
        int         nb;
        int         errs;
        int         fb;
        int         fc;
        logic       fl;
        logic       fbz;
        logic       pbit;
        t = 0;
        while (line[d] !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (line[d] !== 1'b0) begin
            errors++;
            $display("FAIL start_timeout dut%0d: line=%b, required 0 within 2000 cycles",
                     d, line[d]);
            return;
        end
        for (int f = 0; f < n; f++) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty dut%0d frame %0d: got a frame, expected none",
                         d, f);
                return;
            end
            w    = sb_q.pop_front();
            nb   = 0;
            pbit = 1'b0;
            b[nb] = 1'b0;
            nb++;
            for (int i = 0; i < nbits; i++) begin
                b[nb] = w[i];
                pbit  = pbit ^ w[i];
                nb++;
            end
            if (par == 1) begin
                b[nb] = ~pbit;
                nb++;
            end else if (par == 2) begin
                b[nb] = pbit;
                nb++;
            end
            for (int s = 0; s < stops; s++) begin
                b[nb] = 1'b1;
                nb++;
            end
            errs = 0;
            fb   = 0;
            fc   = 0;
            fl   = 1'b0;
            fbz  = 1'b0;
            for (int j = 0; j < nb; j++) begin
                for (int c = 0; c < DIV; c++) begin
                    if (line[d] !== b[j] || busy[d] !== 1'b1) begin
                        if (errs == 0) begin
                            fb  = j;
                            fc  = c;
                            fl  = line[d];
                            fbz = busy[d];
                        end
                        errs++;
                    end
                    @(negedge clk);
                end
            end
            checks++;
            if (errs != 0) begin
                errors++;
                $display("FAIL frame dut%0d word 0x%0h: %0d bad cycles, first at bit %0d cycle %0d line=%b busy=%b, required line=%b busy=1",
                         d, w, errs, fb, fc, fl, fbz, b[fb]);
            end
        end
        checks++;
        if (line[d] !== 1'b1 || busy[d] !== 1'b0) begin
            errors++;
            $display("FAIL idle_after dut%0d: line=%b busy=%b, required line=1 busy=0",
                     d, line[d], busy[d]);
        end
    endtask

    // Presents one word for exactly one accepting edge (FIFO assumed not full)
    task automatic push_one(input int d, input logic [8:0] w);
        data[d]  = w;
        valid[d] = 1'b1;
        sb_q.push_back(w);
        @(negedge clk);
        valid[d] = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (line[d] !== 1'b1 || busy[d] !== 1'b0 || cnt[d] !== 3'd0 || rdy[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_state dut%0d: line=%b busy=%b count=%0d ready=%b, required 1 0 0 1",
                         d, line[d], busy[d], cnt[d], rdy[d]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        data[0]  = 9'h0A5;
        valid[0] = 1'b1;
        sb_q.push_back(9'h0A5);
        @(negedge clk);
        valid[0] = 1'b0;
        checks++;
        if (cnt[0] !== 3'd1 || line[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL accept_latency: count=%0d line=%b busy=%b, required 1 1 0",
                     cnt[0], line[0], busy[0]);
        end
        @(negedge clk);
        checks++;
        if (cnt[0] !== 3'd0 || line[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: count=%0d line=%b busy=%b, required 0 0 1",
                     cnt[0], line[0], busy[0]);
        end
        expect_frames(0, 1, 8, 0, 1);
    endtask

    task automatic test_parity;
        push_one(1, 9'h0A5);
        expect_frames(1, 1, 8, 2, 1);
        push_one(2, 9'h0A5);
        expect_frames(2, 1, 8, 1, 1);
    endtask

    task automatic test_back_to_back;
        data[3]  = 9'h041;
        valid[3] = 1'b1;
        sb_q.push_back(9'h041);
        @(negedge clk);
        data[3] = 9'h042;
        sb_q.push_back(9'h042);
        @(negedge clk);
        valid[3] = 1'b0;
        expect_frames(3, 2, 7, 0, 2);
    endtask

    task automatic test_fifo_full;
        logic [8:0] w [6];
        int         ex;
        for (int k = 0; k < 6; k++) w[k] = 9'(8'h30 + 8'(k * 7));
        push_one(0, w[0]);
        fork
            expect_frames(0, 5, 8, 0, 1);
            begin
                @(negedge clk);
                ex = 0;
                for (int k = 1; k < 6; k++) begin
                    data[0]  = w[k];
                    valid[0] = 1'b1;
                    checks++;
                    if (cnt[0] !== 3'(ex) || rdy[0] !== (ex < 4)) begin
                        errors++;
                        $display("FAIL fill word%0d: count=%0d ready=%b, required %0d %b",
                                 k, cnt[0], rdy[0], ex, (ex < 4));
                    end
                    if (ex < 4) begin
                        sb_q.push_back(w[k]);
                        ex++;
                        @(negedge clk);
                    end else begin
                        repeat (3) begin
                            @(negedge clk);
                            checks++;
                            if (cnt[0] !== 3'd4 || rdy[0] !== 1'b0) begin
                                errors++;
                                $display("FAIL full_hold: count=%0d ready=%b, required 4 0",
                                         cnt[0], rdy[0]);
                            end
                        end
                    end
                end
                valid[0] = 1'b0;
            end
        join
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL fifo_full_leftover: %0d words not emitted, required 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid;
        data[0]  = 9'h0FF;
        valid[0] = 1'b1;
        @(negedge clk);
        data[0] = 9'h03C;
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (DIV + 3 * DIV + DIV / 2) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1 || cnt[0] !== 3'd1) begin
            errors++;
            $display("FAIL pre_reset: busy=%b count=%0d, required 1 1", busy[0], cnt[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (line[0] !== 1'b1 || busy[0] !== 1'b0 || cnt[0] !== 3'd0 || rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: line=%b busy=%b count=%0d ready=%b, required 1 0 0 1",
                     line[0], busy[0], cnt[0], rdy[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (line[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL no_resume: line=%b busy=%b, required 1 0", line[0], busy[0]);
        end
        push_one(0, 9'h05A);
        expect_frames(0, 1, 8, 0, 1);
    endtask

    task automatic test_stream_wrap;
        logic [8:0] w;
        int         t;
        int         bad;
        int         pops_full;
        logic [2:0] prev;
        logic       done;
        bad       = 0;
        pops_full = 0;
        prev      = 3'd0;
        done      = 1'b0;
        fork
            begin
                expect_frames(0, 12, 8, 0, 1);
                done = 1'b1;
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    w        = 9'(8'(k * 37 + 11));
                    data[0]  = w;
                    valid[0] = 1'b1;
                    t = 0;
                    while (rdy[0] !== 1'b1 && t < 400) begin
                        @(negedge clk);
                        t++;
                    end
                    if (rdy[0] !== 1'b1) begin
                        errors++;
                        $display("FAIL stream_ready_timeout word%0d: ready=%b, required 1", k,
                                 rdy[0]);
                        break;
                    end
                    sb_q.push_back(w);
                    @(negedge clk);
                end
                valid[0] = 1'b0;
            end
            begin
                while (!done) begin
                    if (cnt[0] > 3'd4 || rdy[0] !== (cnt[0] != 3'd4)) bad++;
                    if (prev == 3'd4 && cnt[0] == 3'd3) pops_full++;
                    prev = cnt[0];
                    @(negedge clk);
                end
            end
        join
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ready_vs_count: %0d inconsistent cycles, required 0", bad);
        end
        checks++;
        if (pops_full < 3) begin
            errors++;
            $display("FAIL pop_while_full: %0d pops from full, required at least 3", pops_full);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL stream_leftover: %0d words not emitted, required 0", sb_q.size());
        end
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        errors = 0;
        checks = 0;
        for (int d = 0; d < 4; d++) begin
            data[d]  = '0;
            valid[d] = 1'b0;
        end
        test_reset;
        test_basic;
        test_parity;
        test_back_to_back;
        test_fifo_full;
        test_reset_mid;
        test_stream_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
